// File: rtl/card_arb_pkg.sv
// Shared types and defaults for the round-robin card arbiter.
// Optional burst limiting is enabled by defining CARD_ARB_BURST_LIMIT_EN.
package card_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam int DEF_N_REQ     = 8;
  localparam int DEF_DATA_W    = 64;
  localparam int DEF_MAX_BURST = 16;

  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/card_rr_pick.sv
// Rotating priority encoder: first set request after last_grant.
// Pure combinational; shared by the arbiter top.
module card_rr_pick
  import card_arb_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int ID_W  = id_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  last_grant,
  output logic [ID_W-1:0]  pick,
  output logic             any
);

  // Scan circularly starting one past the previous winner.
  always_comb begin
    pick = '0;
    any  = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      if (!any && req[(int'(last_grant) + k) % N_REQ]) begin
        any  = 1'b1;
        pick = ID_W'((int'(last_grant) + k) % N_REQ);
      end
    end
  end

endmodule

// File: rtl/card_rr_arbiter.sv
// Packet-level round-robin arbiter onto one AXI-stream master.
// Define CARD_ARB_BURST_LIMIT_EN to cap each grant at MAX_BURST beats.
module card_rr_arbiter
  import card_arb_pkg::*;
#(
  parameter int N_REQ     = DEF_N_REQ,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [N_REQ-1:0]        s_valid,
  output logic [N_REQ-1:0]        s_ready,
  input  logic [N_REQ*DATA_W-1:0] s_data,
  input  logic [N_REQ-1:0]        s_last,
  output logic [DATA_W-1:0]       m_tdata,
  output logic                    m_tvalid,
  input  logic                    m_tready,
  output logic                    m_tlast
);

  localparam int ID_W = id_w(N_REQ);

  if (MAX_BURST < 1) begin : g_burst_chk
    $error("MAX_BURST must be at least 1");
  end

  state_t          state;
  state_t          state_nx;
  logic [ID_W-1:0] grant;
  logic [ID_W-1:0] last_grant;
  logic [ID_W-1:0] pick;
  logic            any;
  logic            open_out;
  logic            take;
  logic            rel;
  logic [DATA_W-1:0] sel_data;
  logic [DATA_W-1:0] beat_data;

  card_rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_pick (
    .req        (s_valid),
    .last_grant (last_grant),
    .pick       (pick),
    .any        (any)
  );

  assign open_out = !m_tvalid || m_tready;
  assign sel_data = s_data[int'(grant)*DATA_W +: DATA_W];
  assign take     = (state == BUSY) && s_valid[grant] && open_out;

  // Tag the outgoing beat with the winning requester index.
  always_comb begin
    beat_data = sel_data;
    beat_data[ID_W-1:0] = grant;
  end

  // Only the granted requester sees ready, and only in BUSY.
  always_comb begin
    s_ready = '0;
    if (state == BUSY) s_ready[grant] = open_out;
  end

`ifdef CARD_ARB_BURST_LIMIT_EN
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  logic [CNT_W-1:0] beat_cnt;
  logic             burst_end;

  assign burst_end = (beat_cnt == CNT_W'(MAX_BURST - 1));
  assign rel       = take && (s_last[grant] || burst_end);

  // Beats moved under the current grant; cleared on release.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)  beat_cnt <= '0;
    else if (take) beat_cnt <= rel ? '0 : beat_cnt + 1'b1;
  end
`else
  assign rel = take && s_last[grant];
`endif

  // FSM state register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_nx;
  end

  // Arbitrate in IDLE, hold the grant in BUSY until release.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (any) state_nx = BUSY;
      BUSY: if (rel) state_nx = IDLE;
    endcase
  end

  // Grant capture and round-robin pointer.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      grant      <= '0;
      last_grant <= ID_W'(N_REQ - 1);
    end else begin
      if (state == IDLE && any) grant <= pick;
      if (rel) last_grant <= grant;
    end
  end

  // Output register: load on transfer, drain on downstream ready.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_tdata  <= '0;
      m_tlast  <= 1'b0;
      m_tvalid <= 1'b0;
    end else if (take) begin
      m_tdata  <= beat_data;
      m_tlast  <= s_last[grant];
      m_tvalid <= 1'b1;
    end else if (m_tready) begin
      m_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_card_rr_arbiter.sv
// Directed and random bench for card_rr_arbiter.
// Packet-level reference model; define CARD_ARB_BURST_LIMIT_EN for burst mode.
module tb_card_rr_arbiter;

  localparam int N  = 8;
  localparam int W  = 64;
  localparam int IW = 3;
`ifdef CARD_ARB_BURST_LIMIT_EN
  localparam int MB = 4;
`else
  localparam int MB = 16;
`endif

  logic           aclk;
  logic           aresetn;
  logic [N-1:0]   s_valid;
  logic [N-1:0]   s_ready;
  logic [N*W-1:0] s_data;
  logic [N-1:0]   s_last;
  logic [W-1:0]   m_tdata;
  logic           m_tvalid;
  logic           m_tready;
  logic           m_tlast;

  card_rr_arbiter #(
    .N_REQ     (N),
    .DATA_W    (W),
    .MAX_BURST (MB)
  ) dut (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .s_last   (s_last),
    .m_tdata  (m_tdata),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
    .m_tlast  (m_tlast)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;

  logic [64:0] srcq [N][$];
  logic [64:0] expq [N][$];
  bit          en [N];
  logic        tr;

  int owner      = -1;
  int last_owner = N - 1;
  int seg        = 0;
  int j_now      = 0;

  int         bj[$];
  int         bid[$];
  int         own_log[$];
  logic       tl_log[$];
  logic [7:0] rdy_log[$];

  logic        stall_prev = 1'b0;
  logic [63:0] prev_d;
  logic        prev_l;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_pkt(input int r, input int len,
                          input logic [63:0] base, input logic [63:0] step);
    logic [64:0] e;
    for (int b = 0; b < len; b++) begin
      e = {(b == len - 1), base + step * 64'(b)};
      srcq[r].push_back(e);
      expq[r].push_back(e);
    end
  endtask

  function automatic bit model_empty();
    for (int i = 0; i < N; i++)
      if (expq[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  // Reference: each segment goes to the first pending requester
  // after the previous one; beats come out in source order.
  task automatic on_beat(input logic [63:0] d, input logic l);
    logic [64:0] e;
    int nxt;
    if (owner < 0) begin
      nxt = -1;
      for (int k = 1; k <= N; k++)
        if (nxt < 0 && expq[(last_owner + k) % N].size() > 0)
          nxt = (last_owner + k) % N;
      chk("beat_expected", 64'(nxt >= 0), 64'd1);
      if (nxt < 0) return;
      owner = nxt;
      seg   = 0;
      own_log.push_back(nxt);
    end
    e = '0;
    if (expq[owner].size() > 0) e = expq[owner].pop_front();
    chk("beat_data", d, {e[63:IW], IW'(owner)});
    chk("beat_last", 64'(l), 64'(e[64]));
    bid.push_back(int'(d[IW-1:0]));
    bj.push_back(j_now);
    tl_log.push_back(l);
    seg++;
    if (e[64] || seg == MB) begin
      last_owner = owner;
      owner      = -1;
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (en[i] && srcq[i].size() > 0) begin
        s_valid[i]       = 1'b1;
        s_data[i*W +: W] = srcq[i][0][63:0];
        s_last[i]        = srcq[i][0][64];
      end else begin
        s_valid[i]       = 1'b0;
        s_data[i*W +: W] = '0;
        s_last[i]        = 1'b0;
      end
    end
    m_tready = tr;
  endtask

  task automatic tick();
    logic [N-1:0] hs;
    logic         ob;
    logic [63:0]  od;
    logic         ol;
    drive();
    #1;
    hs = s_valid & s_ready;
    ob = m_tvalid & m_tready;
    od = m_tdata;
    ol = m_tlast;
    rdy_log.push_back(s_ready);
    if (stall_prev) begin
      chk("hold_valid", 64'(m_tvalid), 64'd1);
      chk("hold_data", m_tdata, prev_d);
      chk("hold_last", 64'(m_tlast), 64'(prev_l));
    end
    stall_prev = m_tvalid & !m_tready;
    prev_d     = m_tdata;
    prev_l     = m_tlast;
    @(posedge aclk);
    @(negedge aclk);
    for (int i = 0; i < N; i++)
      if (hs[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
    if (ob) on_beat(od, ol);
  endtask

  task automatic clear_logs();
    bj.delete();
    bid.delete();
    own_log.delete();
    tl_log.delete();
    rdy_log.delete();
  endtask

  task automatic run(input string tag, input int budget, input bit rnd,
                     input int st_lo, input int st_hi,
                     input int dr, input int dr_lo, input int dr_hi);
    int j;
    clear_logs();
    j = 0;
    while (!model_empty() && j < budget) begin
      j_now = j;
      if (rnd) tr = ($urandom_range(0, 3) != 0);
      else     tr = !(j >= st_lo && j < st_hi);
      for (int i = 0; i < N; i++)
        en[i] = !(i == dr && j >= dr_lo && j < dr_hi);
      tick();
      j++;
    end
    chk({tag, "_done"}, 64'(model_empty()), 64'd1);
    tr = 1'b1;
    for (int i = 0; i < N; i++) en[i] = 1'b1;
    j_now = j;
    tick();
  endtask

  initial begin
    aresetn = 1'b0;
    tr      = 1'b1;
    for (int i = 0; i < N; i++) en[i] = 1'b1;
    drive();
    @(negedge aclk);
    @(negedge aclk);
    chk("rst_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst_tlast", 64'(m_tlast), 64'd0);
    chk("rst_tdata", m_tdata, 64'd0);
    chk("rst_sready", 64'(s_ready), 64'd0);
    aresetn = 1'b1;
    #1;
    chk("post_rst_sready", 64'(s_ready), 64'd0);

    // All requesters, one-beat packets, full-rate sink.
    for (int r = 0; r < N; r++) push_pkt(r, 1, 64'h1000 + 64'(r * 16), 64'd0);
    push_pkt(0, 1, 64'h2000, 64'd0);
    run("rr", 200, 1'b0, 0, 0, -1, 0, 0);
    chk("rr_nbeats", 64'(bid.size()), 64'd9);
    for (int k = 0; k < bid.size() && k < 9; k++)
      chk("rr_id", 64'(bid[k]), 64'(k % N));
    chk("rr_ready_t0", 64'(rdy_log[0]), 64'h00);
    chk("rr_ready_t1", 64'(rdy_log[1]), 64'h01);
    if (bj.size() > 0) chk("rr_first_lat", 64'(bj[0]), 64'd2);
    for (int k = 1; k < bj.size(); k++)
      chk("rr_gap", 64'(bj[k] - bj[k-1]), 64'd2);

    // Multi-beat packet from 3 with 5 waiting.
    push_pkt(3, 4, 64'hAAAA_0000_0000_0000, 64'd0);
    push_pkt(5, 1, 64'h5555, 64'd0);
    run("pkt4", 200, 1'b0, 0, 0, -1, 0, 0);
    chk("pkt4_nseg", 64'(own_log.size()), 64'd2);
    if (own_log.size() == 2) begin
      chk("pkt4_own0", 64'(own_log[0]), 64'd3);
      chk("pkt4_own1", 64'(own_log[1]), 64'd5);
    end
    for (int k = 0; k < tl_log.size() && k < 4; k++)
      chk("pkt4_tlast", 64'(tl_log[k]), 64'(k == 3));

    // Downstream stall mid-packet.
    push_pkt(2, 8, 64'h0200, 64'd8);
    run("stall", 200, 1'b0, 4, 9, -1, 0, 0);
    chk("stall_nbeats", 64'(bid.size()), 64'd8);
    for (int k = 4; k < 9; k++)
      chk("stall_sready2", 64'(rdy_log[k][2]), 64'd0);

    // Owner drops valid mid-packet while another waits.
    push_pkt(6, 6, 64'h0600, 64'd8);
    push_pkt(1, 1, 64'h0100, 64'd0);
    run("drop", 200, 1'b0, 0, 0, 6, 3, 6);
    for (int k = 3; k < 6; k++)
      chk("drop_hold", 64'(rdy_log[k]), 64'h40);
    chk("drop_nseg", 64'(own_log.size()), 64'd2);
    if (own_log.size() == 2) begin
      chk("drop_own0", 64'(own_log[0]), 64'd6);
      chk("drop_own1", 64'(own_log[1]), 64'd1);
    end

    // Asynchronous reset during beat 2 of a 4-beat packet.
    push_pkt(0, 4, 64'h0A00, 64'd8);
    clear_logs();
    tr = 1'b1;
    for (int j = 0; j < 50 && bid.size() < 1; j++) begin
      j_now = j;
      tick();
    end
    drive();
    #1;
    chk("rst_mid_valid", 64'(m_tvalid), 64'd1);
    chk("rst_mid_data", m_tdata, {expq[0][0][63:IW], 3'd0});
    aresetn = 1'b0;
    #1;
    chk("rst_mid_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst_mid_tdata", m_tdata, 64'd0);
    chk("rst_mid_sready", 64'(s_ready), 64'd0);
    @(posedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
    for (int i = 0; i < N; i++) begin
      srcq[i].delete();
      expq[i].delete();
    end
    owner      = -1;
    last_owner = N - 1;
    stall_prev = 1'b0;
    push_pkt(3, 1, 64'h0300, 64'd0);
    push_pkt(0, 1, 64'h0B00, 64'd0);
    run("rst_after", 200, 1'b0, 0, 0, -1, 0, 0);
    chk("rst_after_nseg", 64'(own_log.size()), 64'd2);
    if (own_log.size() == 2) begin
      chk("rst_after_own0", 64'(own_log[0]), 64'd0);
      chk("rst_after_own1", 64'(own_log[1]), 64'd3);
    end

`ifdef CARD_ARB_BURST_LIMIT_EN
    // Long packet from 0 split by the beat cap around requester 1.
    push_pkt(0, 10, 64'h0C00, 64'd8);
    push_pkt(1, 2, 64'h1100, 64'd8);
    run("burst", 300, 1'b0, 0, 0, -1, 0, 0);
    chk("burst_nseg", 64'(own_log.size()), 64'd4);
    if (own_log.size() == 4) begin
      chk("burst_own0", 64'(own_log[0]), 64'd0);
      chk("burst_own1", 64'(own_log[1]), 64'd1);
      chk("burst_own2", 64'(own_log[2]), 64'd0);
    end
    if (tl_log.size() > 3) chk("burst_tlast4", 64'(tl_log[3]), 64'd0);
`endif

    // Random packets with random backpressure.
    for (int rnd = 0; rnd < 4; rnd++) begin
      for (int r = 0; r < N; r++) begin
        int np;
        np = $urandom_range(0, 3);
        for (int p = 0; p < np; p++)
          push_pkt(r, $urandom_range(1, 5), {$urandom, $urandom},
                   64'($urandom_range(0, 7)));
      end
      run("rand", 3000, 1'b1, 0, 0, -1, 0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
